// File: rtl/mdu.sv
// Multiply/divide unit owning the architectural HI/LO registers.
// mult/multu/div/divu take a fixed number of cycles with busy high; mthi/mtlo write immediately.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // Issue handshake: a request (en=1) is taken on a rising edge only while busy=0;
  // any request seen while busy=1 is dropped without touching state.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [63:0] result;
  logic        div_zero;

  logic        is_mul, is_div;
  logic [63:0] calc;
  logic [31:0] div_a, div_b, div_b_safe, quo, rem;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign busy   = (state == RUN);

  // Signed division is done on magnitudes, then signs are restored; this keeps
  // 0x80000000 / -1 well defined (quotient wraps back to 0x80000000).
  always_comb begin
    div_a      = (op == OP_DIV && A[31]) ? (~A + 32'd1) : A;
    div_b      = (op == OP_DIV && B[31]) ? (~B + 32'd1) : B;
    div_b_safe = (B == 32'd0) ? 32'd1 : div_b;
    quo        = div_a / div_b_safe;
    rem        = div_a % div_b_safe;
    if (op == OP_DIV && (A[31] ^ B[31])) quo = ~quo + 32'd1;
    if (op == OP_DIV && A[31])           rem = ~rem + 32'd1;
    calc = 64'd0;
    unique case (op)
      OP_MULT:  calc = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      OP_MULTU: calc = {32'd0, A} * {32'd0, B};
      OP_DIV,
      OP_DIVU:  calc = {rem, quo};
      default:  calc = 64'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (en && (is_mul || is_div)) state_next = RUN;
      RUN:     if (cnt == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 4'd0;
      result   <= 64'd0;
      div_zero <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else if (state == IDLE) begin
      if (en && (is_mul || is_div)) begin
        result   <= calc;
        div_zero <= is_div && (B == 32'd0);
        cnt      <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end else if (en && op == OP_MTHI) begin
        HI <= A;
      end else if (en && op == OP_MTLO) begin
        LO <= A;
      end
    end else begin
      cnt <= cnt - 4'd1;
      // Divide by zero still burns the full latency but leaves HI/LO alone.
      if (cnt == 4'd1 && !div_zero) begin
        HI <= result[63:32];
        LO <= result[31:0];
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu: directed vector table, hand-written corner sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_mdu;

  logic        clk, reset, en;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One clock: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic cycle(input logic e, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    en = e; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    en = 1'b0; op = 3'd0;
  endtask

  // Counts edges after issue while busy stays high, bounded.
  task automatic wait_idle(input int start, output int n);
    n = start;
    while (busy && n < 40) begin
      cycle(1'b0, 3'd0, 32'd0, 32'd0);
      n++;
    end
  endtask

  // Reference model: architectural effect of one accepted request.
  function automatic void model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd1: begin sq = sa * sb; m_hi = sq[63:32]; m_lo = sq[31:0]; end
      3'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; m_hi = sr[31:0]; m_lo = sq[31:0]; end
      3'd4: if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int model_cycles(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return 5;
    if (o == 3'd3 || o == 3'd4) return 10;
    return 0;
  endfunction

  initial begin
    int n;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'd4, 32'h00001234, 32'h00000000, 32'h00000000, 32'h80000000, 10};

    // Reset and idle
    en = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    cycle(1'b0, 3'd0, 32'd0, 32'd0);
    check("idle_after_reset", {31'd0, busy, HI, LO} , 64'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      model_apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_busy_on_issue", i), {63'd0, busy}, 64'd1);
      wait_idle(0, n);
      check($sformatf("vec%0d_cycles", i), 64'(n), 64'(vecs[i].exp_cycles));
      check($sformatf("vec%0d_hilo", i), {HI, LO}, {vecs[i].exp_hi, vecs[i].exp_lo});
    end

    // mthi / mtlo: immediate, no busy
    cycle(1'b1, 3'd5, 32'h12345678, 32'd0);
    model_apply(3'd5, 32'h12345678, 32'd0);
    check("mthi_hi", {32'd0, HI}, {32'd0, 32'h12345678});
    check("mthi_busy", {63'd0, busy}, 64'd0);
    cycle(1'b1, 3'd6, 32'h9ABCDEF0, 32'd0);
    model_apply(3'd6, 32'h9ABCDEF0, 32'd0);
    check("mtlo_hilo", {HI, LO}, {32'h12345678, 32'h9ABCDEF0});
    check("mtlo_busy", {63'd0, busy}, 64'd0);

    // divu by zero keeps HI/LO
    cycle(1'b1, 3'd4, 32'd55, 32'd0);
    wait_idle(0, n);
    check("div0_cycles", 64'(n), 64'd10);
    check("div0_hilo", {HI, LO}, {32'h12345678, 32'h9ABCDEF0});

    // Requests while busy are ignored
    cycle(1'b1, 3'd1, 32'd3, 32'd4);
    cycle(1'b1, 3'd6, 32'hDEADBEEF, 32'd0);
    cycle(1'b1, 3'd4, 32'd7, 32'd2);
    check("ignored_still_busy", {63'd0, busy}, 64'd1);
    wait_idle(2, n);
    check("ignored_cycles", 64'(n), 64'd5);
    check("ignored_hilo", {HI, LO}, {32'd0, 32'd12});
    repeat (12) cycle(1'b0, 3'd0, 32'd0, 32'd0);
    check("ignored_no_late_update", {31'd0, busy, HI, LO}, {32'd0, 32'd12});

    // Reset in the middle of a divide, asserted between edges
    cycle(1'b1, 3'd3, 32'd100, 32'd7);
    repeat (3) cycle(1'b0, 3'd0, 32'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) cycle(1'b0, 3'd0, 32'd0, 32'd0);
    check("midreset_no_update", {31'd0, busy, HI, LO}, 64'd0);
    cycle(1'b1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(0, n);
    check("post_reset_multu_cycles", 64'(n), 64'd5);
    check("post_reset_multu_hilo", {HI, LO}, {32'hFFFFFFFE, 32'h00000001});
    m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;

    // Random operations against the reference model
    for (int k = 0; k < 60; k++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom();
      r_b  = $urandom();
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'hFFFFFFFF;
        2: r_a = 32'h80000000;
        3: r_b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      cycle(1'b1, r_op, r_a, r_b);
      model_apply(r_op, r_a, r_b);
      if (model_cycles(r_op) > 0) begin
        wait_idle(0, n);
        check($sformatf("rand%0d_op%0d_cycles", k, r_op), 64'(n), 64'(model_cycles(r_op)));
      end else begin
        check($sformatf("rand%0d_op%0d_busy", k, r_op), {63'd0, busy}, 64'd0);
      end
      check($sformatf("rand%0d_op%0d_hilo a=%h b=%h", k, r_op, r_a, r_b), {HI, LO}, {m_hi, m_lo});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
